// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one step per cycle.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_neg_in, b_neg_in;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [63:0] div_next;
  logic [63:0] prod_res;
  logic [31:0] quo_res, rem_res;

  // Signed ops (op[0] = 0) work on magnitudes; the sign is restored in FINISH.
  always_comb begin
    a_neg_in = ~op[0] & a_in[31];
    b_neg_in = ~op[0] & b_in[31];
    a_mag    = a_neg_in ? -a_in : a_in;
    b_mag    = b_neg_in ? -b_in : b_in;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    rem_shift = {acc_q[63:32], acc_q[31]};
    diff      = rem_shift - {1'b0, opnd_q};
    div_next  = diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                         : {diff[31:0], acc_q[30:0], 1'b1};
    prod_res  = neg_q ? -acc_q : acc_q;
    quo_res   = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem_res   = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    busy_d     = (state_q != IDLE);
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          cnt_d     = 5'd0;
          neg_d     = a_neg_in ^ b_neg_in;
          neg_rem_d = a_neg_in;
          if (op[1]) begin
            opnd_d  = b_mag;
            acc_d   = {32'd0, a_mag};
            dz_d    = (b_in == 32'd0);
            state_d = (b_in == 32'd0) ? FINISH : DIV;
          end else begin
            opnd_d  = a_mag;
            acc_d   = {32'd0, b_mag};
            dz_d    = 1'b0;
            state_d = MULT;
          end
        end
      end

      MULT: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = FINISH;
        end
      end

      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (op_q[1]) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod_res[63:32];
          lo_d = prod_res[31:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 2'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of iteration cycles per operation; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation, sampled in IDLE only.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port a_in, input, 32 bits: operand A (multiplicand or dividend), taken from the ALU operand-A path.
REQ-007 SHALL have port b_in, input, 32 bits: operand B (multiplier or divisor), taken from the 5-way operand-B mux output.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port div_zero, output, 1 bit: one-cycle pulse, coincident with done, for DIV or DIVU with b_in = 0.
REQ-011 SHALL have ports hi_out and lo_out, outputs, 32 bits each: the architectural HI and LO registers.

Function
REQ-012 SHALL implement the FSM states IDLE, MULT, DIV and FINISH.
REQ-013 SHALL, in IDLE with start = 1 on edge N, latch a_in, b_in and op, clear the iteration counter, and enter MULT (op[1] = 0) or DIV (op[1] = 1).
REQ-014 SHALL ignore start when not in IDLE; operands SHALL NOT be re-latched mid-operation.
REQ-015 SHALL, for DIV or DIVU with latched divisor 0, go IDLE -> FINISH directly, pulse done and div_zero at edge N+1, and leave HI and LO unchanged.
REQ-016 SHALL, in MULT, perform one shift-add step per cycle for 32 cycles. MULTU uses unsigned operands. MULT uses operand magnitudes and then negates the 64-bit result when the operand signs differ.
REQ-017 SHALL, in DIV, perform one restoring shift-subtract step per cycle for 32 cycles on magnitudes. DIVU uses unsigned operands. For DIV, the quotient is negated if the signs differ and the remainder takes the sign of the dividend (truncation toward zero).
REQ-018 SHALL treat 0x80000000 / 0xFFFFFFFF (DIV) as quotient 0x80000000, remainder 0, with no error flag.
REQ-019 SHALL move from MULT or DIV to FINISH when the counter reaches 31 (the 32nd step).
REQ-020 SHALL, in FINISH, write the results at the same edge that raises done:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: HI = remainder, LO = quotient.
  - done is then high for exactly one cycle, and the FSM returns to IDLE.
REQ-021 SHALL give a normal-operation latency of 33 cycles: start sampled at edge N, done high after edge N+33, HI/LO valid from that edge.
REQ-022 SHALL assert busy from edge N+1 until the edge where done falls; busy SHALL be 0 in IDLE.
REQ-023 SHALL allow start in the cycle after done to begin a new operation with no dead cycle.
REQ-024 SHALL hold HI and LO stable at all times except the FINISH write.

Reset
REQ-025 SHALL, on reset = 1, immediately and regardless of clk:
  - set state to IDLE;
  - set busy, done, div_zero = 0;
  - set hi_out, lo_out = 0x00000000;
  - clear the counter and internal operand/partial registers.
REQ-026 SHALL abort any operation in progress on reset, with no HI/LO update; after release, the first start SHALL behave as from power-up.

Verification
REQ-027 SHALL cover MULT 0xFFFFFFFE x 0x00000003 -> done at cycle 33, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-028 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-029 SHALL cover DIV -7 / 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); and DIVU 100 / 7 -> LO = 14, HI = 2.
REQ-030 SHALL cover DIV 5 / 0 with HI = LO = 0x12345678 preloaded -> done and div_zero pulse 1 cycle after start, HI and LO still 0x12345678.
REQ-031 SHALL cover start toggled at cycle 10 during MULT -> result unaffected and done still at cycle 33.
REQ-032 SHALL cover reset asserted asynchronously at cycle 15 of a DIV -> busy = 0 and HI = LO = 0 immediately, and no done pulse follows.
